// File: rtl/ni_request_flit_sequencer.sv
// Request-path flit sequencer for the NI target side.
// Walks the header shifter through its chunks, then streams payload beats,
// and emits typed flits onto the NoC link under credit-based flow control.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   pkt_valid/ready       packet accept handshake, pkt_payload_len = payload flits
//   busy                  packet in flight (header input must stay stable)
//   flit_counter          header-chunk index to the shifter (registered)
//   is_payload            payload phase select to the shifter (registered)
//   header_chunk          chunk returned by the shifter for flit_counter
//   payload_data/valid/ready  payload beat handshake (ready is combinational)
//   flit_out/flit_valid   registered {ftype, data} flit and its strobe
//   credit_in             one downstream buffer slot freed
module ni_request_flit_sequencer #(
  parameter int unsigned FLIT_WIDTH      = 32,
  parameter int unsigned FTYPEWD         = 2,
  parameter int unsigned REQ_HEADERFLITS = 3,
  parameter int unsigned MAX_PAYLOAD     = 8,
  parameter int unsigned COUNTERFLITWD   = 4,
  parameter int unsigned BUFFER_DEPTH    = 4,
  localparam int unsigned BASE_WIDTH     = FLIT_WIDTH - FTYPEWD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pkt_valid,
  input  logic [COUNTERFLITWD-1:0] pkt_payload_len,
  output logic                     pkt_ready,
  output logic                     busy,
  output logic [COUNTERFLITWD-1:0] flit_counter,
  output logic                     is_payload,
  input  logic [BASE_WIDTH-1:0]    header_chunk,
  input  logic [BASE_WIDTH-1:0]    payload_data,
  input  logic                     payload_valid,
  output logic                     payload_ready,
  output logic [FLIT_WIDTH-1:0]    flit_out,
  output logic                     flit_valid,
  input  logic                     credit_in
);

  localparam int unsigned CREDITWD = $clog2(BUFFER_DEPTH + 1);

  localparam logic [FTYPEWD-1:0]       FT_BODY    = FTYPEWD'(0);
  localparam logic [FTYPEWD-1:0]       FT_HEAD    = FTYPEWD'(1);
  localparam logic [FTYPEWD-1:0]       FT_TAIL    = FTYPEWD'(2);
  localparam logic [COUNTERFLITWD-1:0] LAST_HDR   = COUNTERFLITWD'(REQ_HEADERFLITS - 1);
  localparam logic [COUNTERFLITWD-1:0] MAX_LEN    = COUNTERFLITWD'(MAX_PAYLOAD);
  localparam logic [CREDITWD-1:0]      CREDIT_MAX = CREDITWD'(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTERFLITWD-1:0] len_q, len_d;
  logic [COUNTERFLITWD-1:0] pay_cnt_q, pay_cnt_d;
  logic [COUNTERFLITWD-1:0] flit_cnt_q, flit_cnt_d;
  logic                     is_payload_q, is_payload_d;
  logic [FLIT_WIDTH-1:0]    flit_q, flit_d;
  logic                     flit_valid_q, flit_valid_d;
  logic [CREDITWD-1:0]      credits_q, credits_d;
  logic [FTYPEWD-1:0]       ftype;
  logic                     send;
  logic                     has_credit;

  assign has_credit    = (credits_q != '0);
  assign pkt_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign payload_ready = (state_q == ST_PAYLOAD) && has_credit;
  assign flit_counter  = flit_cnt_q;
  assign is_payload    = is_payload_q;
  assign flit_out      = flit_q;
  assign flit_valid    = flit_valid_q;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      pay_cnt_q    <= '0;
      flit_cnt_q   <= '0;
      is_payload_q <= 1'b0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      credits_q    <= CREDIT_MAX;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pay_cnt_q    <= pay_cnt_d;
      flit_cnt_q   <= flit_cnt_d;
      is_payload_q <= is_payload_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      credits_q    <= credits_d;
    end
  end

  // Next-state and flit generation
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pay_cnt_d    = pay_cnt_q;
    flit_cnt_d   = flit_cnt_q;
    is_payload_d = is_payload_q;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    ftype        = FT_BODY;
    send         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pkt_valid) begin
          len_d        = (pkt_payload_len > MAX_LEN) ? MAX_LEN : pkt_payload_len;
          pay_cnt_d    = '0;
          flit_cnt_d   = '0;
          is_payload_d = 1'b0;
          state_d      = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (has_credit) begin
          send         = 1'b1;
          flit_valid_d = 1'b1;
          ftype        = (flit_cnt_q == '0) ? FT_HEAD : FT_BODY;
          if (flit_cnt_q == LAST_HDR) begin
            // Counter holds on the last chunk; a read ends here
            if (len_q == '0) begin
              ftype   = FT_TAIL;
              state_d = ST_IDLE;
            end else begin
              is_payload_d = 1'b1;
              state_d      = ST_PAYLOAD;
            end
          end else begin
            flit_cnt_d = flit_cnt_q + COUNTERFLITWD'(1);
          end
          flit_d = {ftype, header_chunk};
        end
      end

      ST_PAYLOAD: begin
        if (payload_valid && has_credit) begin
          send         = 1'b1;
          flit_valid_d = 1'b1;
          pay_cnt_d    = pay_cnt_q + COUNTERFLITWD'(1);
          if (pay_cnt_q == len_q - COUNTERFLITWD'(1)) begin
            ftype        = FT_TAIL;
            is_payload_d = 1'b0;
            state_d      = ST_IDLE;
          end
          flit_d = {ftype, payload_data};
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Credit counter: send and return in one cycle cancel, saturates at depth
  always_comb begin
    credits_d = credits_q;
    if (send && !credit_in) begin
      credits_d = credits_q - CREDITWD'(1);
    end else if (!send && credit_in && (credits_q != CREDIT_MAX)) begin
      credits_d = credits_q + CREDITWD'(1);
    end
  end

endmodule

// File: tb/tb_ni_request_flit_sequencer.sv
// Scoreboard bench for ni_request_flit_sequencer: expected flits are queued
// when a packet is offered and compared as the DUT strobes flit_valid.
module tb_ni_request_flit_sequencer;

  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        pkt_valid;
  logic [3:0]  pkt_payload_len;
  logic        pkt_ready;
  logic        busy;
  logic [3:0]  flit_counter;
  logic        is_payload;
  logic [29:0] header_chunk;
  logic [29:0] payload_data;
  logic        payload_valid;
  logic        payload_ready;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        credit_in;

  logic        credit_man;
  logic        credit_auto;
  logic        auto_credit;
  logic        follow_busy;
  logic [7:0]  cur_tag;
  int unsigned beat;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          flits_seen = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          acc_cyc = 0;
  int          pkt_idx = 0;
  int          base;
  logic        isp_at [0:15];
  logic [31:0] exp_q [$];

  ni_request_flit_sequencer dut (
    .clock          (clock),
    .reset          (rst_n),
    .pkt_valid      (pkt_valid),
    .pkt_payload_len(pkt_payload_len),
    .pkt_ready      (pkt_ready),
    .busy           (busy),
    .flit_counter   (flit_counter),
    .is_payload     (is_payload),
    .header_chunk   (header_chunk),
    .payload_data   (payload_data),
    .payload_valid  (payload_valid),
    .payload_ready  (payload_ready),
    .flit_out       (flit_out),
    .flit_valid     (flit_valid),
    .credit_in      (credit_in)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Shifter and payload-source models
  assign header_chunk = {cur_tag, 18'h2A5A5, flit_counter};
  assign payload_data = {cur_tag, 6'h15, 16'(beat)};
  assign credit_in    = credit_man | credit_auto | (follow_busy & busy);

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)                            beat <= 0;
    else if (pkt_valid && pkt_ready)       beat <= 0;
    else if (payload_valid && payload_ready) beat <= beat + 1;
  end

  // Downstream sink that returns a credit the cycle after each flit
  always @(negedge clock) credit_auto = auto_credit && flit_valid && rst_n;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Flit monitor / scoreboard compare
  always @(negedge clock) begin
    logic [31:0] e;
    if (rst_n && flit_valid) begin
      flits_seen++;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_flit", 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check("flit", 64'(flit_out), 64'(e));
        if (e[31:30] == FT_HEAD) begin
          first_cyc = cyc;
          pkt_idx   = 0;
        end
        if (pkt_idx < 16) isp_at[pkt_idx] = is_payload;
        pkt_idx++;
        if (e[31:30] == FT_TAIL) check("busy_after_tail", 64'(busy), 64'(0));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic send_pkt(input logic [3:0] len, input logic [7:0] tag);
    int n = 0;
    int p;
    logic [1:0] ft;
    @(negedge clock);
    while (!pkt_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!pkt_ready) check("pkt_ready_timeout", 64'(pkt_ready), 64'(1));
    cur_tag         = tag;
    pkt_valid       = 1'b1;
    pkt_payload_len = len;
    acc_cyc         = cyc;
    p = (len > 4'd8) ? 8 : int'(len);
    for (int i = 0; i < 3; i++) begin
      ft = (i == 0) ? FT_HEAD : ((i == 2 && p == 0) ? FT_TAIL : FT_BODY);
      exp_q.push_back({ft, tag, 18'h2A5A5, 4'(i)});
    end
    for (int j = 0; j < p; j++) begin
      ft = (j == p - 1) ? FT_TAIL : FT_BODY;
      exp_q.push_back({ft, tag, 6'h15, 16'(j)});
    end
    @(negedge clock);
    pkt_valid = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    #1;
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_credit(input int n);
    @(negedge clock);
    credit_man = 1'b1;
    repeat (n) @(negedge clock);
    credit_man = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_payload_len = '0; payload_valid = 1'b0;
    credit_man = 1'b0; auto_credit = 1'b0; follow_busy = 1'b0; cur_tag = 8'h00;
    #12;
    check("rst_flit_valid", 64'(flit_valid), 64'(0));
    check("rst_flit_out", 64'(flit_out), 64'(0));
    check("rst_flit_counter", 64'(flit_counter), 64'(0));
    check("rst_is_payload", 64'(is_payload), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pkt_ready", 64'(pkt_ready), 64'(1));
    @(negedge clock);
    rst_n = 1'b1;

    // Read packet: HEAD, BODY, TAIL back to back
    auto_credit = 1'b1;
    base = flits_seen;
    send_pkt(4'd0, 8'h11);
    wait_drain(50);
    check("t1_count", 64'(flits_seen - base), 64'(3));
    check("t1_consec", 64'(last_cyc - first_cyc), 64'(2));
    check("t1_latency", 64'(first_cyc - acc_cyc), 64'(2));
    tick(3);

    // Write packet, len 2
    payload_valid = 1'b1;
    base = flits_seen;
    send_pkt(4'd2, 8'h22);
    wait_drain(50);
    check("t2_count", 64'(flits_seen - base), 64'(5));
    check("t2_consec", 64'(last_cyc - first_cyc), 64'(4));
    check("t2_isp_flit2", 64'(isp_at[1]), 64'(0));
    check("t2_isp_flit3", 64'(isp_at[2]), 64'(1));
    tick(3);
    auto_credit = 1'b0;

    // Credit starvation
    base = flits_seen;
    send_pkt(4'd5, 8'h33);
    tick(15);
    check("t3_stall4", 64'(flits_seen - base), 64'(4));
    check("t3_busy_stalled", 64'(busy), 64'(1));
    pulse_credit(1);
    tick(10);
    check("t3_one_more", 64'(flits_seen - base), 64'(5));
    pulse_credit(3);
    tick(10);
    check("t3_done", 64'(flits_seen - base), 64'(8));
    check("t3_idle", 64'(busy), 64'(0));

    // Send and credit in the same cycle at credits == 1
    pulse_credit(1);
    follow_busy = 1'b1;
    base = flits_seen;
    send_pkt(4'd3, 8'h44);
    wait_drain(50);
    follow_busy = 1'b0;
    check("t4_count", 64'(flits_seen - base), 64'(6));
    check("t4_consec", 64'(last_cyc - first_cyc), 64'(5));
    base = flits_seen;
    send_pkt(4'd0, 8'h45);
    tick(10);
    check("t4_credit_stayed_1", 64'(flits_seen - base), 64'(1));
    pulse_credit(6);
    tick(5);
    check("t4_read_done", 64'(flits_seen - base), 64'(3));
    pulse_credit(2);
    base = flits_seen;
    send_pkt(4'd5, 8'h46);
    tick(15);
    check("t4_saturate_at_4", 64'(flits_seen - base), 64'(4));
    pulse_credit(4);
    tick(10);
    check("t4_done", 64'(flits_seen - base), 64'(8));

    // Length clamp
    pulse_credit(4);
    auto_credit = 1'b1;
    base = flits_seen;
    send_pkt(4'd15, 8'h55);
    wait_drain(80);
    check("t5_count", 64'(flits_seen - base), 64'(11));
    check("t5_consec", 64'(last_cyc - first_cyc), 64'(10));
    tick(3);

    // Reset in the middle of the payload phase
    base = flits_seen;
    send_pkt(4'd6, 8'h66);
    n = 0;
    while ((flits_seen - base) < 5 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("t6_mid_valid", 64'(flit_valid), 64'(1));
    check("t6_mid_isp", 64'(is_payload), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_flit_valid", 64'(flit_valid), 64'(0));
    check("t6_rst_flit_counter", 64'(flit_counter), 64'(0));
    check("t6_rst_is_payload", 64'(is_payload), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    auto_credit = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    base = flits_seen;
    send_pkt(4'd5, 8'h67);
    check("t6_fc_zero", 64'(flit_counter), 64'(0));
    tick(15);
    check("t6_credits_4", 64'(flits_seen - base), 64'(4));
    pulse_credit(4);
    wait_drain(30);
    check("t6_done", 64'(flits_seen - base), 64'(8));

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
